cmi_inval_queue: RTL and testbench

CMI_INVAL_QUEUE -- requirements
Module: cmi_inval_queue

---
 rtl/cmi_inval_queue.sv | 92 +++++++++
 tb/tb_cmi_inval_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cmi_inval_queue.sv
// CMI DMA-write invalidate queue: 4-entry address FIFO feeding cache invalidates.
// Optional build macro INVAL_MERGE_EN: drop a write to the same quadword as the newest entry.
module cmi_inval_queue (
    input  logic        b_clk_l,
    input  logic        mseq_init_l,
    input  logic        snapshot_cmi_l,
    input  logic [21:0] cmi_addr_h,
    input  logic        inval_ack_h,
    input  logic        clr_overflow_h,
    output logic        inval_req_h,
    output logic [21:0] inval_addr_h,
    output logic        inval_hold_l,
    output logic        inval_overflow_h
);

    logic [21:0] mem_q [4];
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        snap_del_q;
    logic        hold_l_q, hold_l_d;
    logic        ovf_q, ovf_d;

    logic enq_edge, push_req, pop, push, full, ovf_set;

    // Falling edge of the snapshot strobe; snap_del resets low so a strobe
    // already asserted at reset release is not taken as a new write.
    assign enq_edge = snap_del_q && !snapshot_cmi_l;
    assign full     = (count_q == 3'd4);
    assign pop      = inval_ack_h && (count_q != 3'd0);

`ifdef INVAL_MERGE_EN
    logic [1:0] last_ptr;
    logic       merge_hit;
    assign last_ptr  = wr_ptr_q - 2'd1;
    assign merge_hit = (count_q != 3'd0) &&
                       (mem_q[last_ptr][21:1] == cmi_addr_h[21:1]);
    assign push_req  = enq_edge && !merge_hit;
`else
    assign push_req  = enq_edge;
`endif

    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
        if (push) wr_ptr_d = wr_ptr_q + 2'd1;
        case ({push, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
        hold_l_d = (count_d < 3'd3);
        ovf_d    = ovf_q;
        if (ovf_set)             ovf_d = 1'b1;
        else if (clr_overflow_h) ovf_d = 1'b0;
    end

    always_ff @(posedge b_clk_l or negedge mseq_init_l) begin
        if (!mseq_init_l) begin
            rd_ptr_q   <= 2'd0;
            wr_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            snap_del_q <= 1'b0;
            hold_l_q   <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            snap_del_q <= snapshot_cmi_l;
            hold_l_q   <= hold_l_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset; the count gates whether any entry is meaningful.
    always_ff @(posedge b_clk_l) begin
        if (push) mem_q[wr_ptr_q] <= cmi_addr_h;
    end

    assign inval_req_h      = (count_q != 3'd0);
    assign inval_addr_h     = mem_q[rd_ptr_q];
    assign inval_hold_l     = hold_l_q;
    assign inval_overflow_h = ovf_q;

endmodule

// File: tb/tb_cmi_inval_queue.sv
// Self-checking bench for cmi_inval_queue: directed vectors, corner sequences, random vs. queue model.
module tb_cmi_inval_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snap = 1'b0;
    logic [21:0] addr = '0;
    logic        ack = 1'b0;
    logic        clr = 1'b0;
    logic        req, hold_l, ovf;
    logic [21:0] iaddr;

    int nerr = 0;
    int nchk = 0;

`ifdef INVAL_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    cmi_inval_queue dut (
        .b_clk_l         (clk),
        .mseq_init_l     (rst_n),
        .snapshot_cmi_l  (snap),
        .cmi_addr_h      (addr),
        .inval_ack_h     (ack),
        .clr_overflow_h  (clr),
        .inval_req_h     (req),
        .inval_addr_h    (iaddr),
        .inval_hold_l    (hold_l),
        .inval_overflow_h(ovf)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue of addresses plus a sticky flag.
    logic [21:0] mq [$];
    bit          movf = 1'b0;
    bit          mprev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic s, input logic [21:0] a, input logic k, input logic c);
        bit edge_s, pop_s, was_full, merged;
        edge_s   = mprev && !s;
        mprev    = s;
        pop_s    = k && (mq.size() > 0);
        was_full = (mq.size() == 4);
        merged   = MERGE && edge_s && (mq.size() > 0) && (mq[mq.size()-1][21:1] == a[21:1]);
        if (pop_s) void'(mq.pop_front());
        if (edge_s && !merged) begin
            if (was_full && !pop_s) movf = 1'b1;
            else begin
                mq.push_back(a);
                if (c) movf = movf;
            end
        end
        if (edge_s && !merged && was_full && !pop_s) movf = 1'b1;
        else if (c) movf = 1'b0;
    endtask

    task automatic cmp_model();
        chk("model_req", req, mq.size() != 0);
        if (mq.size() != 0) chk("model_addr", iaddr, mq[0]);
        chk("model_hold", hold_l, mq.size() < 3);
        chk("model_ovf", ovf, movf);
    endtask

    // Called at a falling edge: drive, take one rising edge, compare at the next falling edge.
    task automatic step(input logic s, input logic [21:0] a, input logic k, input logic c);
        snap = s; addr = a; ack = k; clr = c;
        @(posedge clk);
        model_edge(s, a, k, c);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset(input logic s, input int offs);
        @(negedge clk);
        snap = s; ack = 1'b0; clr = 1'b0;
        #(offs);
        rst_n = 1'b0;
        #1;
        chk("rst_req", req, 1'b0);
        chk("rst_hold", hold_l, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        mq.delete(); movf = 1'b0; mprev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        s;
        logic [21:0] a;
        logic        k;
        logic        c;
        logic        er;
        logic [21:0] ea;
        logic        eh;
        logic        eo;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [21:0] ra;
        tbl[0]  = '{1'b1, 22'h0,   1'b0, 1'b0, 1'b0, 22'h0,   1'b1, 1'b0};
        tbl[1]  = '{1'b0, 22'h100, 1'b0, 1'b0, 1'b1, 22'h100, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 22'h0,   1'b1, 1'b0, 1'b0, 22'h0,   1'b1, 1'b0};
        tbl[3]  = '{1'b0, 22'h1,   1'b0, 1'b0, 1'b1, 22'h1,   1'b1, 1'b0};
        tbl[4]  = '{1'b1, 22'h0,   1'b0, 1'b0, 1'b1, 22'h1,   1'b1, 1'b0};
        tbl[5]  = '{1'b0, 22'h2,   1'b0, 1'b0, 1'b1, 22'h1,   1'b1, 1'b0};
        tbl[6]  = '{1'b1, 22'h0,   1'b0, 1'b0, 1'b1, 22'h1,   1'b1, 1'b0};
        tbl[7]  = '{1'b0, 22'h3,   1'b0, 1'b0, 1'b1, 22'h1,   1'b0, 1'b0};
        tbl[8]  = '{1'b1, 22'h0,   1'b0, 1'b0, 1'b1, 22'h1,   1'b0, 1'b0};
        tbl[9]  = '{1'b0, 22'h4,   1'b0, 1'b0, 1'b1, 22'h1,   1'b0, 1'b0};
        tbl[10] = '{1'b1, 22'h0,   1'b0, 1'b0, 1'b1, 22'h1,   1'b0, 1'b0};
        tbl[11] = '{1'b0, 22'h5,   1'b0, 1'b0, 1'b1, 22'h1,   1'b0, 1'b1};
        tbl[12] = '{1'b1, 22'h0,   1'b1, 1'b0, 1'b1, 22'h2,   1'b0, 1'b1};
        tbl[13] = '{1'b1, 22'h0,   1'b1, 1'b0, 1'b1, 22'h3,   1'b1, 1'b1};
        tbl[14] = '{1'b1, 22'h0,   1'b1, 1'b0, 1'b1, 22'h4,   1'b1, 1'b1};
        tbl[15] = '{1'b1, 22'h0,   1'b1, 1'b0, 1'b0, 22'h0,   1'b1, 1'b1};
        tbl[16] = '{1'b1, 22'h0,   1'b0, 1'b1, 1'b0, 22'h0,   1'b1, 1'b0};

        // Strobe already low across reset release must not enqueue.
        do_reset(1'b0, 0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 22'h3ABCDE, 1'b0, 1'b0);
            chk("snap_low_no_enq", req, 1'b0);
        end

        // Directed vectors: single entry, fill, overflow, drain, clear.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].s, tbl[i].a, tbl[i].k, tbl[i].c);
            chk($sformatf("vec%0d_req", i), req, tbl[i].er);
            if (tbl[i].er) chk($sformatf("vec%0d_addr", i), iaddr, tbl[i].ea);
            chk($sformatf("vec%0d_hold", i), hold_l, tbl[i].eh);
            chk($sformatf("vec%0d_ovf", i), ovf, tbl[i].eo);
        end

        // Full queue with simultaneous edge and ack: both happen, no overflow.
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 22'(k), 1'b0, 1'b0);
            step(1'b1, 22'h0, 1'b0, 1'b0);
        end
        step(1'b0, 22'h9, 1'b1, 1'b0);
        chk("full_pushpop_addr", iaddr, 22'h2);
        chk("full_pushpop_hold", hold_l, 1'b0);
        chk("full_pushpop_ovf", ovf, 1'b0);
        step(1'b1, 22'h0, 1'b1, 1'b0); chk("drain_3", iaddr, 22'h3);
        step(1'b1, 22'h0, 1'b1, 1'b0); chk("drain_4", iaddr, 22'h4);
        step(1'b1, 22'h0, 1'b1, 1'b0); chk("drain_9", iaddr, 22'h9);
        step(1'b1, 22'h0, 1'b1, 1'b0); chk("drain_empty", req, 1'b0);

        // Ack on empty, then enqueue/pop pairs across pointer wrap.
        step(1'b1, 22'h0, 1'b1, 1'b0);
        chk("empty_ack_req", req, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 22'h20 + 22'(k), 1'b0, 1'b0);
            chk($sformatf("wrap%0d_addr", k), iaddr, 22'h20 + 22'(k));
            step(1'b1, 22'h0, 1'b1, 1'b0);
            chk($sformatf("wrap%0d_req", k), req, 1'b0);
        end

        // Enqueue to empty with simultaneous ack: ack ignored, entry accepted.
        step(1'b0, 22'h55, 1'b1, 1'b0);
        chk("empty_enq_ack_addr", iaddr, 22'h55);
        step(1'b1, 22'h0, 1'b1, 1'b0);

        // Neighbouring longwords in one quadword.
        step(1'b0, 22'h10, 1'b0, 1'b0);
        step(1'b1, 22'h0, 1'b0, 1'b0);
        step(1'b0, 22'h11, 1'b0, 1'b0);
        step(1'b1, 22'h0, 1'b1, 1'b0);
        chk("merge_req", req, !MERGE);
        if (!MERGE) chk("merge_addr", iaddr, 22'h11);
        step(1'b1, 22'h0, 1'b1, 1'b0);
        chk("merge_drained", req, 1'b0);

        // Coincident overflow and clear: set wins.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 22'h40 + 22'(k*2), 1'b0, 1'b0);
            step(1'b1, 22'h0, 1'b0, 1'b0);
        end
        step(1'b0, 22'h77, 1'b0, 1'b1);
        chk("ovf_set_wins", ovf, 1'b1);

        // Mid-cycle reset with entries in flight: nothing re-offered.
        do_reset(1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 22'h0, 1'b0, 1'b0);
            chk("post_rst_req", req, 1'b0);
        end

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? 22'($urandom_range(0, 15)) : 22'($urandom);
            step($urandom_range(0, 2) != 0, ra, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
